keypad_scanner: RTL and testbench

Parametrised matrix-keypad scanner. It drives the keypad columns itself, synchronises and debounces the row returns, and encodes each confirmed press into a key code. Each code is delivered with a valid/acknowledge handshake. The block sits between the keypad pins and the display/control logic, and replaces the fixed 4x4 encoder that needed an external column counter.

---
 rtl/keypad_scanner.sv | 239 +++++++++++++++++++++++
 tb/tb_keypad_scanner.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : Matrix-keypad scanner. Drives one-cold columns, synchronises and
//             debounces the row returns, encodes confirmed presses into key
//             codes and hands them over with a valid/acknowledge handshake.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scanner #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int SCAN_DIV  = 1000,
    parameter int DB_FRAMES = 4,
    parameter int HEX_MAP   = 1,
    localparam int CODE_W   = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    output logic [COLS-1:0]   col_drive,
    input  logic [ROWS-1:0]   row_in,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    input  logic              key_ack,
    output logic              key_pressed,
    output logic              overrun
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DB_FRAMES + 1);

    localparam logic [DIV_W-1:0] C_DWELL_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [COL_W-1:0] C_COL_LAST   = COL_W'(COLS - 1);
    localparam logic [CNT_W-1:0] C_DB_LAST    = CNT_W'(DB_FRAMES - 1);

    localparam logic [1:0] S_SCAN    = 2'd0;
    localparam logic [1:0] S_CONFIRM = 2'd1;
    localparam logic [1:0] S_HELD    = 2'd2;

    logic [ROWS-1:0]   r_sync1;
    logic [ROWS-1:0]   r_rs;
    logic [DIV_W-1:0]  r_dwell;
    logic [COL_W-1:0]  r_col;
    logic [1:0]        r_state;
    logic [ROW_W-1:0]  r_cand_row;
    logic [ROWS-1:0]   r_cand_pat;
    logic [CNT_W-1:0]  r_match;
    logic [CNT_W-1:0]  r_rel;
    logic [CODE_W-1:0] r_code;
    logic              r_valid;
    logic              r_overrun;

    logic              w_sample;
    logic [ROWS-1:0]   w_low;
    logic              w_one_low;
    logic [ROW_W-1:0]  w_row_idx;
    logic [CODE_W-1:0] w_code;
    logic [1:0]        w_state_nxt;
    logic              w_col_adv;
    logic              w_latch;
    logic              w_match_inc;
    logic              w_load;
    logic              w_rel_inc;
    logic              w_rel_clr;

    // Two-flop synchroniser for the asynchronous row returns (idle = all ones)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '1;
            r_rs    <= '1;
        end else begin
            r_sync1 <= row_in;
            r_rs    <= r_sync1;
        end
    end

    // Dwell counter; every column/state change happens on its wrap cycle,
    // so a free-running modulo count restarts at 0 on each change
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dwell <= '0;
        end else if (w_sample) begin
            r_dwell <= '0;
        end else begin
            r_dwell <= r_dwell + DIV_W'(1);
        end
    end

    assign w_sample = (r_dwell == C_DWELL_LAST);

    // Row decode: detect exactly one low row and find its index
    always_comb begin
        w_low     = ~r_rs;
        w_one_low = (w_low != '0) && ((w_low & (w_low - ROWS'(1))) == '0);
        w_row_idx = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (!r_rs[i]) begin
                w_row_idx = ROW_W'(i);
            end
        end
    end

    // Key code encoding from the latched candidate row and frozen column
    generate
        if (HEX_MAP != 0) begin : g_hex_map
            assign w_code = CODE_W'((32'(r_cand_row) * 32'd4 + 32'(r_col) + 32'd1) % 32'd16);
        end else begin : g_linear_map
            assign w_code = CODE_W'(32'(r_cand_row) * 32'(COLS) + 32'(r_col));
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_SCAN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and datapath strobes, evaluated only at sample points
    always_comb begin
        w_state_nxt = r_state;
        w_col_adv   = 1'b0;
        w_latch     = 1'b0;
        w_match_inc = 1'b0;
        w_load      = 1'b0;
        w_rel_inc   = 1'b0;
        w_rel_clr   = 1'b0;
        if (w_sample) begin
            case (r_state)
                S_SCAN: begin
                    if (w_one_low) begin
                        w_latch     = 1'b1;
                        w_state_nxt = S_CONFIRM;
                    end else begin
                        w_col_adv = 1'b1;
                    end
                end
                S_CONFIRM: begin
                    if (r_rs == r_cand_pat) begin
                        if (r_match == C_DB_LAST) begin
                            w_load      = 1'b1;
                            w_state_nxt = S_HELD;
                        end else begin
                            w_match_inc = 1'b1;
                        end
                    end else begin
                        w_col_adv   = 1'b1;
                        w_state_nxt = S_SCAN;
                    end
                end
                S_HELD: begin
                    if (&r_rs) begin
                        if (r_rel == C_DB_LAST) begin
                            w_col_adv   = 1'b1;
                            w_state_nxt = S_SCAN;
                        end else begin
                            w_rel_inc = 1'b1;
                        end
                    end else begin
                        w_rel_clr = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_SCAN;
                end
            endcase
        end
    end

    // Column index, candidate latch and debounce counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_col      <= '0;
            r_cand_row <= '0;
            r_cand_pat <= '1;
            r_match    <= '0;
            r_rel      <= '0;
        end else begin
            if (w_col_adv) begin
                r_col <= (r_col == C_COL_LAST) ? '0 : r_col + COL_W'(1);
            end
            if (w_latch) begin
                r_cand_row <= w_row_idx;
                r_cand_pat <= r_rs;
            end
            if (w_state_nxt != r_state) begin
                r_match <= '0;
                r_rel   <= '0;
            end else begin
                if (w_match_inc) begin
                    r_match <= r_match + CNT_W'(1);
                end
                if (w_rel_clr) begin
                    r_rel <= '0;
                end else if (w_rel_inc) begin
                    r_rel <= r_rel + CNT_W'(1);
                end
            end
        end
    end

    // Output handshake: a load wins over an acknowledge in the same cycle
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_code    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_code <= w_code;
            end
            if (w_load) begin
                r_valid <= 1'b1;
            end else if (key_ack) begin
                r_valid <= 1'b0;
            end
            if (w_load && r_valid && !key_ack) begin
                r_overrun <= 1'b1;
            end else if (key_ack) begin
                r_overrun <= 1'b0;
            end
        end
    end

    // FSM outputs: one-cold column drive and held-key indication
    always_comb begin
        col_drive   = ~(COLS'(1) << r_col);
        key_pressed = (r_state == S_HELD);
    end

    assign key_code  = r_code;
    assign key_valid = r_valid;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_scanner
//  Purpose  : Directed self-checking bench for keypad_scanner, with a 4x4
//             hex-map instance and a 2x3 linear-map instance driven by a
//             simple physical keypad model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_scanner;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       reset_n_l;

    logic [3:0] col_drive_h;
    logic [3:0] row_in_h;
    logic [3:0] key_code_h;
    logic       key_valid_h;
    logic       key_ack;
    logic       key_pressed_h;
    logic       overrun_h;
    logic [3:0][3:0] press_h;

    logic [2:0] col_drive_l;
    logic [1:0] row_in_l;
    logic [2:0] key_code_l;
    logic       key_valid_l;
    logic       key_ack_l;
    logic       key_pressed_l;
    logic       overrun_l;
    logic [1:0][2:0] press_l;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    keypad_scanner #(
        .ROWS(4), .COLS(4), .SCAN_DIV(4), .DB_FRAMES(3), .HEX_MAP(1)
    ) dut_hex (
        .clock       (clock),
        .reset_n     (reset_n),
        .col_drive   (col_drive_h),
        .row_in      (row_in_h),
        .key_code    (key_code_h),
        .key_valid   (key_valid_h),
        .key_ack     (key_ack),
        .key_pressed (key_pressed_h),
        .overrun     (overrun_h)
    );

    keypad_scanner #(
        .ROWS(2), .COLS(3), .SCAN_DIV(4), .DB_FRAMES(3), .HEX_MAP(0)
    ) dut_lin (
        .clock       (clock),
        .reset_n     (reset_n_l),
        .col_drive   (col_drive_l),
        .row_in      (row_in_l),
        .key_code    (key_code_l),
        .key_valid   (key_valid_l),
        .key_ack     (key_ack_l),
        .key_pressed (key_pressed_l),
        .overrun     (overrun_l)
    );

    // Physical keypad: a pressed key pulls its row low while its column is driven
    always_comb begin
        row_in_h = '1;
        for (int r = 0; r < 4; r++) begin
            row_in_h[r] = ~|(press_h[r] & ~col_drive_h);
        end
    end

    always_comb begin
        row_in_l = '1;
        for (int r = 0; r < 2; r++) begin
            row_in_l[r] = ~|(press_l[r] & ~col_drive_l);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_col_h(input logic [3:0] pat);
        int n = 0;
        while (col_drive_h !== pat && n < 64) begin
            @(negedge clock);
            n++;
        end
        check("wait_col_h", 32'(col_drive_h), 32'(pat));
    endtask

    task automatic wait_col_l(input logic [2:0] pat);
        int n = 0;
        while (col_drive_l !== pat && n < 64) begin
            @(negedge clock);
            n++;
        end
        check("wait_col_l", 32'(col_drive_l), 32'(pat));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] exp_col;
        reset_n   = 1'b0;
        reset_n_l = 1'b0;
        key_ack   = 1'b0;
        key_ack_l = 1'b0;
        press_h   = '0;
        press_l   = '0;
        tick(3);

        // Reset values
        check("rst_col",     32'(col_drive_h),   32'hE);
        check("rst_code",    32'(key_code_h),    32'h0);
        check("rst_valid",   32'(key_valid_h),   32'h0);
        check("rst_pressed", 32'(key_pressed_h), 32'h0);
        check("rst_overrun", 32'(overrun_h),     32'h0);
        reset_n   = 1'b1;
        reset_n_l = 1'b1;

        // Idle scan: each column for 4 clocks, outputs quiet
        for (int k = 0; k < 16; k++) begin
            exp_col = 4'b0001 << (k / 4);
            exp_col = ~exp_col;
            check("idle_col", 32'(col_drive_h), 32'(exp_col));
            check("idle_out", 32'({key_valid_h, key_pressed_h, overrun_h}), 32'h0);
            tick(1);
        end

        // Single press at row 1 / column 2 -> hex code 7
        press_h[1][2] = 1'b1;
        wait_col_h(4'b1011);
        tick(15);
        check("press_early_valid", 32'(key_valid_h), 32'h0);
        tick(1);
        check("press_valid",   32'(key_valid_h),   32'h1);
        check("press_pressed", 32'(key_pressed_h), 32'h1);
        check("press_code",    32'(key_code_h),    32'h7);
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        check("ack_valid",   32'(key_valid_h),   32'h0);
        check("ack_pressed", 32'(key_pressed_h), 32'h1);
        press_h = '0;
        tick(10);
        check("release_hold_pressed", 32'(key_pressed_h), 32'h1);
        check("release_hold_col",     32'(col_drive_h),   32'hB);
        tick(1);
        check("release_pressed", 32'(key_pressed_h), 32'h0);
        check("release_col",     32'(col_drive_h),   32'h7);

        // Bounce: row 0 low for two samples, then released during CONFIRM
        press_h[0][0] = 1'b1;
        wait_col_h(4'b1110);
        tick(8);
        check("bounce_frozen", 32'(col_drive_h), 32'hE);
        press_h = '0;
        tick(3);
        check("bounce_frozen2", 32'(col_drive_h), 32'hE);
        tick(1);
        check("bounce_resume", 32'(col_drive_h), 32'hD);
        check("bounce_out", 32'({key_valid_h, key_pressed_h, overrun_h}), 32'h0);

        // Multi-key: rows 0 and 3 on column 1 never produce a candidate
        press_h[0][1] = 1'b1;
        press_h[3][1] = 1'b1;
        tick(4);
        check("multi_col1", 32'(col_drive_h), 32'hB);
        tick(16);
        check("multi_col2", 32'(col_drive_h), 32'hB);
        check("multi_out", 32'({key_valid_h, key_pressed_h, overrun_h, key_code_h}), 32'h7);

        // Overrun: key 0 (row 3, col 3) left unacknowledged, then key 1
        press_h = '0;
        press_h[3][3] = 1'b1;
        wait_col_h(4'b0111);
        tick(16);
        check("ovr_first_valid", 32'(key_valid_h), 32'h1);
        check("ovr_first_code",  32'(key_code_h),  32'h0);
        check("ovr_first_flag",  32'(overrun_h),   32'h0);
        press_h = '0;
        press_h[0][0] = 1'b1;
        tick(27);
        check("ovr_pre_code", 32'(key_code_h), 32'h0);
        check("ovr_pre_flag", 32'(overrun_h),  32'h0);
        tick(1);
        check("ovr_code",  32'(key_code_h),  32'h1);
        check("ovr_flag",  32'(overrun_h),   32'h1);
        check("ovr_valid", 32'(key_valid_h), 32'h1);
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        check("ovr_ack_valid", 32'(key_valid_h), 32'h0);
        check("ovr_ack_flag",  32'(overrun_h),   32'h0);

        // Load coincident with acknowledge: valid stays, no overrun
        press_h = '0;
        press_h[0][1] = 1'b1;
        tick(27);
        check("coin_first_valid", 32'(key_valid_h), 32'h1);
        check("coin_first_code",  32'(key_code_h),  32'h2);
        press_h = '0;
        press_h[0][2] = 1'b1;
        tick(27);
        check("coin_pre_code", 32'(key_code_h), 32'h2);
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        check("coin_valid", 32'(key_valid_h), 32'h1);
        check("coin_code",  32'(key_code_h),  32'h3);
        check("coin_flag",  32'(overrun_h),   32'h0);
        key_ack = 1'b1;
        tick(1);
        key_ack = 1'b0;
        check("coin_ack_valid", 32'(key_valid_h), 32'h0);
        press_h = '0;

        // Linear map, 2x3: row 1 on column 2 -> code 5
        wait_col_l(3'b110);
        press_l[1][2] = 1'b1;
        wait_col_l(3'b011);
        tick(15);
        check("lin_early_valid", 32'(key_valid_l), 32'h0);
        tick(1);
        check("lin_valid",   32'(key_valid_l),   32'h1);
        check("lin_pressed", 32'(key_pressed_l), 32'h1);
        check("lin_code",    32'(key_code_l),    32'h5);

        // Reset while confirming a press on column 1
        press_l = '0;
        press_l[0][1] = 1'b1;
        tick(22);
        check("lin_confirm_col",  32'(col_drive_l), 32'h5);
        check("lin_confirm_code", 32'(key_code_l),  32'h5);
        reset_n_l = 1'b0;
        #1;
        check("lin_rst_col",  32'(col_drive_l), 32'h6);
        check("lin_rst_code", 32'(key_code_l),  32'h0);
        check("lin_rst_out",  32'({key_valid_l, key_pressed_l, overrun_l}), 32'h0);
        tick(2);
        press_l   = '0;
        reset_n_l = 1'b1;
        tick(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
